// File: rtl/axi_mem_slv_pkg.sv
// Shared types and constants for the AXI4 memory slave.
package axi_mem_slv_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

  // Only full-width INCR and FIXED bursts are served; anything else is answered with SLVERR.
  function automatic logic burst_err(input logic [2:0] size, input burst_e burst,
                                     input logic [2:0] full_size);
    return (size != full_size) || (burst == BURST_WRAP) || (burst == BURST_RSVD);
  endfunction

endpackage

// File: rtl/axi_mem_slv_ram.sv
// Simple dual-port RAM: byte-enable write port, registered read port.
// Contents are deliberately not reset. A read and write of the same word in
// one cycle returns the old contents.
module axi_mem_slv_ram #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                re,
  input  logic [IDX_W-1:0]    raddr,
  output logic [DATA_W-1:0]   rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Byte-lane writes.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (we && wstrb[b]) begin
        mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Read register only updates on a read request, so the output holds while the beat is stalled.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_mem_slv.sv
// AXI4 full slave backed by a word-addressed dual-port RAM. Write and read
// channels run independently; no ID signals.
//
// Write FSM
//   state  | meaning
//   W_IDLE | awready high, waiting for an address
//   W_DATA | wready high, accepting beats until count == len
//   W_RESP | bvalid high, waiting for bready
//
// Read FSM
//   state  | meaning
//   R_IDLE | arready high, waiting for an address
//   R_DATA | rvalid high, streaming beats until rlast handshakes
module axi_mem_slv
  import axi_mem_slv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  localparam int NB    = DATA_W / 8;
  localparam int BO    = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [2:0] FULL_SIZE = 3'(BO);

  // Upper address bits alias the memory and byte-offset bits are ignored.
  logic unused_addr;
  assign unused_addr = ^{s_axi_awaddr[ADDR_W-1:IDX_W+BO], s_axi_awaddr[BO-1:0],
                         s_axi_araddr[ADDR_W-1:IDX_W+BO], s_axi_araddr[BO-1:0]};

  // ---------------- write channel ----------------
  wstate_e          wstate_q, wstate_d;
  logic             awready_q, awready_d;
  logic             wready_q, wready_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [7:0]       wlen_q, wlen_d;
  burst_e           wburst_q, wburst_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic             werr_q, werr_d;
  logic             w_is_last;
  logic             w_last_bad;
  logic             ram_we;

  // Write FSM next state: address latch, beat counting, error tracking, response.
  always_comb begin
    wstate_d   = wstate_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    widx_d     = widx_q;
    wlen_d     = wlen_q;
    wburst_d   = wburst_q;
    wcnt_d     = wcnt_q;
    werr_d     = werr_q;
    ram_we     = 1'b0;
    w_is_last  = 1'b0;
    w_last_bad = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (s_axi_awvalid && awready_q) begin
          widx_d    = s_axi_awaddr[IDX_W+BO-1:BO];
          wlen_d    = s_axi_awlen;
          wburst_d  = burst_e'(s_axi_awburst);
          wcnt_d    = 8'd0;
          werr_d    = burst_err(s_axi_awsize, burst_e'(s_axi_awburst), FULL_SIZE);
          wstate_d  = W_DATA;
          awready_d = 1'b0;
          wready_d  = 1'b1;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid && wready_q) begin
          ram_we     = !werr_q;
          w_is_last  = (wcnt_q == wlen_q);
          w_last_bad = (s_axi_wlast != w_is_last);
          wcnt_d     = wcnt_q + 8'd1;
          if (wburst_q == BURST_INCR) begin
            widx_d = widx_q + IDX_W'(1);
          end
          if (w_last_bad) begin
            werr_d = 1'b1;
          end
          if (w_is_last) begin
            wstate_d = W_RESP;
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = (werr_q || w_last_bad) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready && bvalid_q) begin
          wstate_d  = W_IDLE;
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
        end
      end
      default: begin
        wstate_d  = W_IDLE;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // Write channel registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      widx_q    <= '0;
      wlen_q    <= 8'd0;
      wburst_q  <= BURST_FIXED;
      wcnt_q    <= 8'd0;
      werr_q    <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      widx_q    <= widx_d;
      wlen_q    <= wlen_d;
      wburst_q  <= wburst_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
    end
  end

  // ---------------- read channel ----------------
  rstate_e          rstate_q, rstate_d;
  logic             arready_q, arready_d;
  logic             rvalid_q, rvalid_d;
  logic             rlast_q, rlast_d;
  logic [1:0]       rresp_q, rresp_d;
  logic [IDX_W-1:0] ridx_q, ridx_d;
  logic [7:0]       rlen_q, rlen_d;
  burst_e           rburst_q, rburst_d;
  logic [7:0]       rcnt_q, rcnt_d;
  logic             rerr_q, rerr_d;
  logic             ram_re;
  logic [IDX_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;
  logic             ar_err;

  // Read FSM next state: the RAM read for beat n+1 is issued on the handshake of beat n.
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    ridx_d    = ridx_q;
    rlen_d    = rlen_q;
    rburst_d  = rburst_q;
    rcnt_d    = rcnt_q;
    rerr_d    = rerr_q;
    ram_re    = 1'b0;
    ram_raddr = ridx_q;
    ar_err    = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (s_axi_arvalid && arready_q) begin
          ar_err    = burst_err(s_axi_arsize, burst_e'(s_axi_arburst), FULL_SIZE);
          ridx_d    = s_axi_araddr[IDX_W+BO-1:BO];
          rlen_d    = s_axi_arlen;
          rburst_d  = burst_e'(s_axi_arburst);
          rcnt_d    = 8'd0;
          rerr_d    = ar_err;
          ram_re    = 1'b1;
          ram_raddr = s_axi_araddr[IDX_W+BO-1:BO];
          rstate_d  = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rlast_d   = (s_axi_arlen == 8'd0);
          rresp_d   = ar_err ? RESP_SLVERR : RESP_OKAY;
        end
      end
      R_DATA: begin
        if (rvalid_q && s_axi_rready) begin
          if (rlast_q) begin
            rstate_d  = R_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            rresp_d   = RESP_OKAY;
            arready_d = 1'b1;
          end else begin
            rcnt_d = rcnt_q + 8'd1;
            if (rburst_q == BURST_INCR) begin
              ridx_d = ridx_q + IDX_W'(1);
            end
            ram_re    = 1'b1;
            ram_raddr = ridx_d;
            rlast_d   = ((rcnt_q + 8'd1) == rlen_q);
          end
        end
      end
      default: begin
        rstate_d  = R_IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
      end
    endcase
  end

  // Read channel registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      ridx_q    <= '0;
      rlen_q    <= 8'd0;
      rburst_q  <= BURST_FIXED;
      rcnt_q    <= 8'd0;
      rerr_q    <= 1'b0;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      ridx_q    <= ridx_d;
      rlen_q    <= rlen_d;
      rburst_q  <= rburst_d;
      rcnt_q    <= rcnt_d;
      rerr_q    <= rerr_d;
    end
  end

  axi_mem_slv_ram #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk  (aclk),
    .we   (ram_we),
    .waddr(widx_q),
    .wdata(s_axi_wdata),
    .wstrb(s_axi_wstrb),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rresp   = rresp_q;
  // Error bursts and idle cycles return zero data; the RAM register is not reset.
  assign s_axi_rdata   = (rvalid_q && !rerr_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_axi_mem_slv.sv
// Directed bench for axi_mem_slv.
module tb_axi_mem_slv;

  logic        aclk;
  logic        aresetn;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  axi_mem_slv #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] wr_data [256];
  logic [31:0] rd_data [256];
  logic        rd_last [256];
  logic [1:0]  rd_resp [256];
  int          rd_n, rd_cyc;
  int          stall_err = 0;
  logic        first_rvalid, wready_lat, bvalid_lat;
  logic [1:0]  wr_bresp;

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] strb, input bit rnd,
                          input bit bad_last);
    int cyc; bit hs; int nb; logic [1:0] bheld; bit bstall;
    awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    cyc = 0; hs = 1'b0;
    while (!hs && cyc < 50) begin
      hs = awready;
      @(posedge aclk); #1; cyc++;
    end
    awvalid = 1'b0;
    if (!hs) chk("aw_timeout", 0, 1);
    wready_lat = wready;
    nb = 0; cyc = 0;
    while (nb <= int'(len) && cyc < 2000) begin
      wvalid = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
      wdata  = wr_data[nb];
      wstrb  = strb;
      wlast  = bad_last ? 1'b0 : (nb == int'(len));
      hs = wvalid && wready;
      @(posedge aclk); #1; cyc++;
      if (hs) nb++;
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (nb <= int'(len)) chk("w_timeout", 64'(nb), 64'(int'(len) + 1));
    bvalid_lat = bvalid;
    cyc = 0; hs = 1'b0; bstall = 1'b0; bheld = 2'b00;
    while (!hs && cyc < 2000) begin
      bready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
      if (bstall && bresp !== bheld) stall_err++;
      hs = bvalid && bready;
      if (!hs && bvalid) begin bstall = 1'b1; bheld = bresp; end
      wr_bresp = bresp;
      @(posedge aclk); #1; cyc++;
    end
    bready = 1'b0;
    if (!hs) chk("b_timeout", 0, 1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input bit rnd);
    int cyc; bit hs; int nb; bit stalled; logic [31:0] held;
    araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    cyc = 0; hs = 1'b0;
    while (!hs && cyc < 50) begin
      hs = arready;
      @(posedge aclk); #1; cyc++;
    end
    arvalid = 1'b0;
    if (!hs) chk("ar_timeout", 0, 1);
    first_rvalid = rvalid;
    nb = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (nb <= int'(len) && cyc < 2000) begin
      rready = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
      if (stalled && rdata !== held) stall_err++;
      hs = rvalid && rready;
      if (hs) begin
        rd_data[nb] = rdata; rd_last[nb] = rlast; rd_resp[nb] = rresp;
        nb++; stalled = 1'b0;
      end else if (rvalid) begin
        stalled = 1'b1; held = rdata;
      end
      @(posedge aclk); #1; cyc++;
    end
    rready = 1'b0;
    rd_n = nb; rd_cyc = cyc;
    if (nb <= int'(len)) chk("r_timeout", 64'(nb), 64'(int'(len) + 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    aresetn = 1'b0;
    awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

    // Reset state and ready rise after release
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_outs", {awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, rdata}, 0);
    aresetn = 1'b1;
    #1;
    chk("ready_pre_edge", {awready, arready}, 2'b00);
    @(posedge aclk); #1;
    chk("ready_post_edge", {awready, arready}, 2'b11);

    // Single write/read
    wr_data[0] = 32'hDEADBEEF;
    do_write(32'h0, 8'd0, 3'd2, 2'd1, 4'hF, 1'b0, 1'b0);
    chk("single_wready_lat", wready_lat, 1);
    chk("single_bvalid_lat", bvalid_lat, 1);
    chk("single_bresp", wr_bresp, 2'b00);
    do_read(32'h0, 8'd0, 3'd2, 2'd1, 1'b0);
    chk("single_rvalid_lat", first_rvalid, 1);
    chk("single_rdata", rd_data[0], 32'hDEADBEEF);
    chk("single_rlast_resp", {rd_last[0], rd_resp[0]}, 3'b100);
    chk("single_rvalid_drop", rvalid, 0);

    // Byte strobes: lanes 0 and 2 only
    wr_data[0] = 32'h11223344;
    do_write(32'h0, 8'd0, 3'd2, 2'd1, 4'h5, 1'b0, 1'b0);
    do_read(32'h0, 8'd0, 3'd2, 2'd1, 1'b0);
    chk("strb_rdata", rd_data[0], 32'hDE22BE44);
    // Aliasing modulo DEPTH words (4 KiB)
    do_read(32'h1000, 8'd0, 3'd2, 2'd1, 1'b0);
    chk("alias_rdata", rd_data[0], 32'hDE22BE44);

    // INCR len 3, back-to-back read
    for (int i = 0; i < 4; i++) wr_data[i] = 32'(i + 1);
    do_write(32'h100, 8'd3, 3'd2, 2'd1, 4'hF, 1'b0, 1'b0);
    chk("incr_bresp", wr_bresp, 2'b00);
    do_read(32'h100, 8'd3, 3'd2, 2'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("incr_rdata%0d", i), rd_data[i], 32'(i + 1));
      chk($sformatf("incr_rlast%0d", i), rd_last[i], (i == 3) ? 1'b1 : 1'b0);
    end
    chk("incr_b2b_cycles", 64'(rd_cyc), 4);

    // FIXED len 3: last beat wins
    wr_data[0] = 32'hA; wr_data[1] = 32'hB; wr_data[2] = 32'hC; wr_data[3] = 32'hD;
    do_write(32'h40, 8'd3, 3'd2, 2'd0, 4'hF, 1'b0, 1'b0);
    chk("fixed_bresp", wr_bresp, 2'b00);
    do_read(32'h40, 8'd0, 3'd2, 2'd1, 1'b0);
    chk("fixed_rdata", rd_data[0], 32'hD);

    // Narrow write is absorbed with SLVERR, memory unchanged
    wr_data[0] = 32'h12345678;
    do_write(32'h80, 8'd0, 3'd2, 2'd1, 4'hF, 1'b0, 1'b0);
    wr_data[0] = 32'hFFFFFFFF; wr_data[1] = 32'hFFFFFFFF;
    do_write(32'h80, 8'd1, 3'd1, 2'd1, 4'hF, 1'b0, 1'b0);
    chk("narrow_bresp", wr_bresp, 2'b10);
    do_read(32'h80, 8'd0, 3'd2, 2'd1, 1'b0);
    chk("narrow_mem_kept", rd_data[0], 32'h12345678);

    // WRAP read: zero data, SLVERR, two beats
    do_read(32'h100, 8'd1, 3'd2, 2'd2, 1'b0);
    chk("wrap_beats", 64'(rd_n), 2);
    chk("wrap_beat0", {rd_data[0], rd_resp[0], rd_last[0]}, {32'h0, 2'b10, 1'b0});
    chk("wrap_beat1", {rd_data[1], rd_resp[1], rd_last[1]}, {32'h0, 2'b10, 1'b1});

    // wlast mismatch: SLVERR, data still written
    wr_data[0] = 32'h00005555;
    do_write(32'h84, 8'd0, 3'd2, 2'd1, 4'hF, 1'b0, 1'b1);
    chk("wlast_bad_bresp", wr_bresp, 2'b10);
    do_read(32'h84, 8'd0, 3'd2, 2'd1, 1'b0);
    chk("wlast_bad_rdata", rd_data[0], 32'h00005555);

    // Back-pressure on INCR len 7
    for (int i = 0; i < 8; i++) wr_data[i] = 32'h200 + 32'(i);
    do_write(32'h200, 8'd7, 3'd2, 2'd1, 4'hF, 1'b1, 1'b0);
    chk("bp_bresp", wr_bresp, 2'b00);
    do_read(32'h200, 8'd7, 3'd2, 2'd1, 1'b1);
    chk("bp_beats", 64'(rd_n), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bp_rdata%0d", i), rd_data[i], 32'h200 + 32'(i));
      chk($sformatf("bp_rlast%0d", i), rd_last[i], (i == 7) ? 1'b1 : 1'b0);
    end
    chk("bp_payload_stable", 64'(stall_err), 0);

    // Reset mid read burst
    araddr = 32'h200; arlen = 8'd7; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
    begin
      int cyc; bit hs;
      cyc = 0; hs = 1'b0;
      while (!hs && cyc < 50) begin
        hs = arready;
        @(posedge aclk); #1; cyc++;
      end
      if (!hs) chk("rst_ar_timeout", 0, 1);
    end
    arvalid = 1'b0;
    rready = 1'b1;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    chk("rst_mid_rvalid", rvalid, 1);
    rready = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("rst_mid_read_outs", {awready, wready, bvalid, arready, rvalid, rlast}, 0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("rst_release_rdy", {awready, arready}, 2'b11);

    // Reset mid write burst: beats already written stay
    for (int i = 0; i < 4; i++) wr_data[i] = 32'hA0 + 32'(i);
    do_write(32'h300, 8'd3, 3'd2, 2'd1, 4'hF, 1'b0, 1'b0);
    awaddr = 32'h300; awlen = 8'd3; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
    begin
      int cyc; bit hs;
      cyc = 0; hs = 1'b0;
      while (!hs && cyc < 50) begin
        hs = awready;
        @(posedge aclk); #1; cyc++;
      end
      if (!hs) chk("rst_aw_timeout", 0, 1);
    end
    awvalid = 1'b0;
    wstrb = 4'hF; wvalid = 1'b1; wlast = 1'b0;
    wdata = 32'h11;
    @(posedge aclk); #1;
    wdata = 32'h22;
    @(posedge aclk); #1;
    wvalid = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("rst_mid_write_outs", {awready, wready, bvalid, arready, rvalid, rlast}, 0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    do_read(32'h300, 8'd3, 3'd2, 2'd1, 1'b0);
    chk("partial_beat0", rd_data[0], 32'h11);
    chk("partial_beat1", rd_data[1], 32'h22);
    chk("partial_beat2", rd_data[2], 32'hA2);
    chk("partial_beat3", rd_data[3], 32'hA3);
    chk("post_rst_rresp", {rd_resp[0], rd_resp[3]}, 4'b0000);
    wr_data[0] = 32'h33;
    do_write(32'h304, 8'd0, 3'd2, 2'd1, 4'hF, 1'b0, 1'b0);
    chk("post_rst_bresp", wr_bresp, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
